// File: rtl/pu_rf_mc.sv
// Multi-context register file: NCTX private register sets, NRD registered read ports, one write
// port, hardwired-zero r0, base-address preload on reset and a per-context reinit sequencer.
module pu_rf_mc #(
   parameter int WIDTH       = 32,
   parameter int DEPTH_NBITS = 5,
   parameter int NCTX_NBITS  = 2,
   parameter int NRD         = 2,
   parameter int BYPASS      = 1,
   parameter logic [WIDTH-1:0] CONNECTION_CONTEXT_BASE    = WIDTH'(32'h1000_0000),
   parameter logic [WIDTH-1:0] SWITCH_INFO_BASE           = WIDTH'(32'h1100_0000),
   parameter logic [WIDTH-1:0] INST_BASE                  = WIDTH'(32'h1200_0000),
   parameter logic [WIDTH-1:0] META_BASE                  = WIDTH'(32'h1300_0000),
   parameter logic [WIDTH-1:0] TOPIC_MEM_BASE             = WIDTH'(32'h1400_0000),
   parameter logic [WIDTH-1:0] FLOW_MEM_BASE              = WIDTH'(32'h1500_0000),
   parameter logic [WIDTH-1:0] PD_BASE                    = WIDTH'(32'h1600_0000),
   parameter logic [WIDTH-1:0] SCRATCH_BASE               = WIDTH'(32'h1700_0000),
   parameter logic [WIDTH-1:0] REGISTERS_BASE             = WIDTH'(32'h1800_0000),
   parameter logic [WIDTH-1:0] TAG_LOOKUP_REQ_MEM_BASE    = WIDTH'(32'h1900_0000),
   parameter logic [WIDTH-1:0] TAG_LOOKUP_RESULT_MEM_BASE = WIDTH'(32'h1A00_0000),
   parameter logic [WIDTH-1:0] RAS_BASE                   = WIDTH'(32'h1F00_0000)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NRD*NCTX_NBITS-1:0]   rctx,
   input  logic [NRD*DEPTH_NBITS-1:0]  raddr,
   output logic [NRD*WIDTH-1:0]        dout,
   input  logic                        wr,
   input  logic [NCTX_NBITS-1:0]       wctx,
   input  logic [DEPTH_NBITS-1:0]      waddr,
   input  logic [WIDTH-1:0]            din,
   input  logic                        init_req,
   input  logic [NCTX_NBITS-1:0]       init_ctx,
   output logic                        init_gnt,
   output logic                        init_done,
   output logic [(1<<NCTX_NBITS)-1:0]  ctx_busy
);
   localparam int DEPTH = 1 << DEPTH_NBITS;
   localparam int NCTX  = 1 << NCTX_NBITS;

   typedef enum logic {S_IDLE, S_INIT} state_t;

   state_t                 state_q;
   logic [DEPTH_NBITS-1:0] ptr_q;
   logic [NCTX_NBITS-1:0]  ictx_q;
   logic [NCTX-1:0]        ctx_busy_q;
   logic                   init_done_q;
   logic [WIDTH-1:0]       mem_q [NCTX][DEPTH];
   logic [NRD*WIDTH-1:0]   dout_q, dout_d;
   logic                   wr_ok;
   logic [NCTX_NBITS-1:0]  rc;
   logic [DEPTH_NBITS-1:0] ra;

   function automatic logic [WIDTH-1:0] preload(input logic [DEPTH_NBITS-1:0] a);
      case (int'(a))
         8:       return CONNECTION_CONTEXT_BASE;
         9:       return SWITCH_INFO_BASE;
         10:      return INST_BASE;
         11:      return META_BASE;
         12:      return TOPIC_MEM_BASE;
         13:      return FLOW_MEM_BASE;
         14:      return PD_BASE;
         15:      return SCRATCH_BASE;
         16:      return REGISTERS_BASE;
         17:      return TAG_LOOKUP_REQ_MEM_BASE;
         18:      return TAG_LOOKUP_RESULT_MEM_BASE;
         31:      return RAS_BASE;
         default: return '0;
      endcase
   endfunction

   assign init_gnt  = init_req && (state_q == S_IDLE);
   assign init_done = init_done_q;
   assign ctx_busy  = ctx_busy_q;
   assign dout      = dout_q;

   // A write racing the grant for its own context would be overwritten by the reinit, so drop it.
   assign wr_ok = wr && (waddr != '0) && !ctx_busy_q[wctx] && !(init_gnt && (init_ctx == wctx));

   always_comb begin
      dout_d = '0;
      rc     = '0;
      ra     = '0;
      for (int k = 0; k < NRD; k++) begin
         rc = rctx[k*NCTX_NBITS +: NCTX_NBITS];
         ra = raddr[k*DEPTH_NBITS +: DEPTH_NBITS];
         if (ra == '0)
            dout_d[k*WIDTH +: WIDTH] = '0;
         else if ((BYPASS != 0) && wr_ok && (wctx == rc) && (waddr == ra))
            dout_d[k*WIDTH +: WIDTH] = din;
         else
            dout_d[k*WIDTH +: WIDTH] = mem_q[rc][ra];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCTX; c++)
            for (int a = 0; a < DEPTH; a++)
               mem_q[c][a] <= preload(DEPTH_NBITS'(a));
      end else begin
         if (wr_ok)
            mem_q[wctx][waddr] <= din;
         if (state_q == S_INIT)
            mem_q[ictx_q][ptr_q] <= preload(ptr_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dout_q <= '0;
      else
         dout_q <= dout_d;
   end

   // init_done is raised one edge early so that it coincides with the cycle of the last write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         ictx_q      <= '0;
         ctx_busy_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         init_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (init_gnt) begin
                  state_q              <= S_INIT;
                  ictx_q               <= init_ctx;
                  ptr_q                <= '0;
                  ctx_busy_q           <= '0;
                  ctx_busy_q[init_ctx] <= 1'b1;
               end
            end
            S_INIT: begin
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == DEPTH_NBITS'(DEPTH-2))
                  init_done_q <= 1'b1;
               if (ptr_q == DEPTH_NBITS'(DEPTH-1)) begin
                  state_q    <= S_IDLE;
                  ctx_busy_q <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_pu_rf_mc.sv
// Randomized self-checking bench for pu_rf_mc against a cycle-indexed reference model.
module tb_pu_rf_mc;
   localparam int WIDTH = 32;
   localparam int DB    = 5;
   localparam int CB    = 2;
   localparam int NRD   = 2;
   localparam int BYP   = 1;
   localparam int DEPTH = 1 << DB;
   localparam int NCTX  = 1 << CB;

   localparam logic [31:0] C_CONN = 32'hC0DE_0008;
   localparam logic [31:0] C_SW   = 32'h5171_0009;
   localparam logic [31:0] C_INST = 32'h1257_000A;
   localparam logic [31:0] C_META = 32'h3E7A_000B;
   localparam logic [31:0] C_TOP  = 32'h7091_000C;
   localparam logic [31:0] C_FLOW = 32'hF10E_000D;
   localparam logic [31:0] C_PD   = 32'h00BD_000E;
   localparam logic [31:0] C_SCR  = 32'h5C2A_000F;
   localparam logic [31:0] C_REGS = 32'h2E65_0010;
   localparam logic [31:0] C_TLQ  = 32'h7A60_0011;
   localparam logic [31:0] C_TLR  = 32'h7A61_0012;
   localparam logic [31:0] C_RAS  = 32'h2A50_001F;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NRD*CB-1:0]     rctx;
   logic [NRD*DB-1:0]     raddr;
   logic [NRD*WIDTH-1:0]  dout;
   logic                  wr;
   logic [CB-1:0]         wctx;
   logic [DB-1:0]         waddr;
   logic [WIDTH-1:0]      din;
   logic                  init_req;
   logic [CB-1:0]         init_ctx;
   logic                  init_gnt;
   logic                  init_done;
   logic [NCTX-1:0]       ctx_busy;

   pu_rf_mc #(
      .WIDTH(WIDTH), .DEPTH_NBITS(DB), .NCTX_NBITS(CB), .NRD(NRD), .BYPASS(BYP),
      .CONNECTION_CONTEXT_BASE(C_CONN), .SWITCH_INFO_BASE(C_SW), .INST_BASE(C_INST),
      .META_BASE(C_META), .TOPIC_MEM_BASE(C_TOP), .FLOW_MEM_BASE(C_FLOW), .PD_BASE(C_PD),
      .SCRATCH_BASE(C_SCR), .REGISTERS_BASE(C_REGS), .TAG_LOOKUP_REQ_MEM_BASE(C_TLQ),
      .TAG_LOOKUP_RESULT_MEM_BASE(C_TLR), .RAS_BASE(C_RAS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rctx(rctx), .raddr(raddr), .dout(dout),
      .wr(wr), .wctx(wctx), .waddr(waddr), .din(din),
      .init_req(init_req), .init_ctx(init_ctx), .init_gnt(init_gnt),
      .init_done(init_done), .ctx_busy(ctx_busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference state: register contents plus the cycle number of the latest grant.
   logic [31:0] m [NCTX][DEPTH];
   logic [31:0] exp_dout [NRD];
   int          cyc = 0;
   bit          have_init = 0;
   int          t_gnt = 0;
   int          ictx = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] pre(input int a);
      case (a)
         8: return C_CONN;   9: return C_SW;    10: return C_INST;  11: return C_META;
         12: return C_TOP;   13: return C_FLOW; 14: return C_PD;    15: return C_SCR;
         16: return C_REGS;  17: return C_TLQ;  18: return C_TLR;   31: return C_RAS;
         default: return 32'h0;
      endcase
   endfunction

   function automatic bit busy_at(input int c, input int t);
      return have_init && (c == ictx) && (t >= t_gnt + 1) && (t <= t_gnt + DEPTH);
   endfunction

   function automatic bit idle_at(input int t);
      return !have_init || (t > t_gnt + DEPTH);
   endfunction

   function automatic bit done_at(input int t);
      return have_init && (t == t_gnt + DEPTH);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCTX; c++)
         for (int a = 0; a < DEPTH; a++)
            m[c][a] = pre(a);
      have_init = 0;
   endtask

   task automatic idle_inputs();
      rctx = '0; raddr = '0; wr = 1'b0; wctx = '0; waddr = '0; din = '0;
      init_req = 1'b0; init_ctx = '0;
   endtask

   task automatic set_rd(input int k, input int c, input int a);
      rctx[k*CB +: CB]  = CB'(c);
      raddr[k*DB +: DB] = DB'(a);
   endtask

   task automatic set_wr(input bit en, input int c, input int a, input logic [31:0] d);
      wr = en; wctx = CB'(c); waddr = DB'(a); din = d;
   endtask

   // Called just after an active edge with the inputs for cycle cyc already driven.
   task automatic step();
      bit eg, wok;
      int rc, ra;
      #1;
      eg = init_req && idle_at(cyc);
      chk("init_gnt", {63'b0, init_gnt}, {63'b0, eg});
      wok = wr && (waddr != 0) && !busy_at(int'(wctx), cyc) && !(eg && (init_ctx == wctx));
      for (int k = 0; k < NRD; k++) begin
         rc = int'(rctx[k*CB +: CB]);
         ra = int'(raddr[k*DB +: DB]);
         if (ra == 0)
            exp_dout[k] = 32'h0;
         else if (BYP != 0 && wok && int'(wctx) == rc && int'(waddr) == ra)
            exp_dout[k] = din;
         else
            exp_dout[k] = m[rc][ra];
      end
      if (busy_at(ictx, cyc))
         m[ictx][cyc - t_gnt - 1] = pre(cyc - t_gnt - 1);
      if (wok)
         m[wctx][waddr] = din;
      if (eg) begin
         have_init = 1;
         t_gnt     = cyc;
         ictx      = int'(init_ctx);
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < NRD; k++)
         chk($sformatf("dout%0d", k), {32'b0, dout[k*WIDTH +: WIDTH]}, {32'b0, exp_dout[k]});
      for (int c = 0; c < NCTX; c++)
         chk($sformatf("ctx_busy%0d", c), {63'b0, ctx_busy[c]}, {63'b0, busy_at(c, cyc)});
      chk("init_done", {63'b0, init_done}, {63'b0, done_at(cyc)});
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_dout"}, {32'b0, dout}, 64'h0);
      chk({tag, "_busy"}, {60'b0, ctx_busy}, 64'h0);
      chk({tag, "_done"}, {63'b0, init_done}, 64'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Preload visibility on ctx3.
      set_rd(0, 3, 8); set_rd(1, 3, 31); step();
      chk("pre_r8",  {32'b0, dout[31:0]},  {32'b0, C_CONN});
      chk("pre_r31", {32'b0, dout[63:32]}, {32'b0, C_RAS});
      set_rd(0, 3, 5); set_rd(1, 3, 18); step();

      // Write with same-cycle read of the same register, and of another context.
      idle_inputs();
      set_wr(1, 1, 7, 32'hDEAD_BEEF); set_rd(0, 1, 7); set_rd(1, 2, 7); step();
      idle_inputs(); set_rd(0, 1, 7); set_rd(1, 2, 7); step();

      // r0 stays zero.
      idle_inputs(); set_wr(1, 0, 0, 32'h1234); step();
      idle_inputs(); step();

      // Reinit ctx2 with concurrent writes and a rejected second request.
      set_wr(1, 2, 9, 32'hAAAA); step();
      idle_inputs(); set_rd(0, 2, 9); init_req = 1'b1; init_ctx = 2'd2; step();
      idle_inputs(); set_wr(1, 2, 20, 32'h55); step();
      idle_inputs(); set_wr(1, 0, 20, 32'h66); init_req = 1'b1; init_ctx = 2'd1; step();
      for (int i = 0; i < 4; i++) step();
      idle_inputs();
      for (int i = 0; i < DEPTH; i++) step();
      set_rd(0, 2, 9); set_rd(1, 2, 20); step();
      set_rd(0, 0, 20); set_rd(1, 2, 0); step();

      // Reset during an active reinit.
      idle_inputs(); set_wr(1, 0, 3, 32'h77); step();
      idle_inputs(); set_rd(0, 0, 3); step();
      idle_inputs(); init_req = 1'b1; init_ctx = 2'd1; step();
      idle_inputs();
      for (int i = 0; i < 11; i++) step();
      rst_n = 1'b0;
      #2;
      check_reset_outputs("midreset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      idle_inputs();
      for (int c = 0; c < NCTX; c++)
         for (int a = 0; a < DEPTH; a += 2) begin
            set_rd(0, c, a); set_rd(1, c, a + 1); step();
         end

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         set_rd(0, $urandom_range(0, NCTX-1), $urandom_range(0, DEPTH-1));
         set_rd(1, $urandom_range(0, NCTX-1), $urandom_range(0, DEPTH-1));
         set_wr($urandom_range(0, 1), $urandom_range(0, NCTX-1), $urandom_range(0, DEPTH-1), $urandom);
         if ($urandom_range(0, 3) == 0) begin
            rctx[CB-1:0] = wctx;
            raddr[DB-1:0] = waddr;
         end
         init_req = ($urandom_range(0, 99) < 4);
         init_ctx = CB'($urandom_range(0, NCTX-1));
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/pu_rf_mc.md
# pu_rf_mc

Multi-context register file for the packet processing unit, replacing the single-context 32x32 register file so that several packet threads can each hold a private register set. Each context gives NRD synchronous read ports, one write port, and hardwired-zero r0. Each context powers up with the system base-address constants preloaded, and a sequencer can reinitialise any single context at run time. It sits between the PU decode stage (reads) and the PU writeback stage (writes).

## Interface
- WIDTH, 32, register data width
- DEPTH_NBITS, 5, log2 registers per context (DEPTH = 1<<DEPTH_NBITS)
- NCTX_NBITS, 2, log2 number of contexts (NCTX = 1<<NCTX_NBITS)
- NRD, 2, number of read ports
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rctx  in  NRD*NCTX_NBITS  read context per port (port k at [k*NCTX_NBITS +: NCTX_NBITS])
- raddr  in  NRD*DEPTH_NBITS  read address per port
- dout  out  NRD*WIDTH  registered read data per port
- wr  in  1  write enable
- wctx  in  NCTX_NBITS  write context
- waddr  in  DEPTH_NBITS  write address
- din  in  WIDTH  write data
- init_req  in  1  request reinitialisation of context init_ctx
- init_ctx  in  NCTX_NBITS  context to reinitialise
- init_gnt  out  1  combinational: init_req & FSM in IDLE
- init_done  out  1  one-cycle pulse on the last reinit write
- ctx_busy  out  NCTX  per-context "reinit in progress" flags

## Operation
- Preload value P(a) by register address a:
  - 8: CONNECTION_CONTEXT_BASE
  - 9: SWITCH_INFO_BASE
  - 10: INST_BASE
  - 11: META_BASE
  - 12: TOPIC_MEM_BASE
  - 13: FLOW_MEM_BASE
  - 14: PD_BASE
  - 15: SCRATCH_BASE
  - 16: REGISTERS_BASE
  - 17: TAG_LOOKUP_REQ_MEM_BASE
  - 18: TAG_LOOKUP_RESULT_MEM_BASE
  - 31: RAS_BASE
  - all other addresses: 0
  - All constants come from defines.vh. If DEPTH<32, addresses at or above DEPTH do not exist.
- Reset (rst_n low):
  - every entry of every context is set to P(a)
  - dout = 0, init_done = 0, ctx_busy = 0, FSM = IDLE, pointer = 0
- r0: reads always return 0; writes to address 0 are dropped.
- Read: each port k independently registers mem[rctx_k][raddr_k] into its dout slice every cycle. There is no read enable.
- Bypass (BYPASS=1): if wr accepted, wctx==rctx_k and waddr==raddr_k (nonzero), dout_k gets din instead of the stale array value. With BYPASS=0, dout_k gets the old value.
- Write: mem[wctx][waddr] <= din when wr, waddr!=0 and the write is not blocked.
  - A write is blocked when ctx_busy[wctx] is set.
  - A write is also blocked when init_gnt is high in the same cycle with init_ctx==wctx.
  - A blocked write is silently dropped and is not forwarded.
- Reinit FSM states: IDLE, INIT.
  - IDLE: on init_gnt, latch init_ctx, pointer <= 0, go to INIT.
  - INIT: write P(pointer) into latched context at pointer, pointer++. On pointer==DEPTH-1, pulse init_done and return to IDLE.
  - init_req in INIT is not granted; the requester holds it.
- Writes to contexts other than the one being reinitialised proceed normally during INIT.
- Reads of a busy context return the current array content, whether partially reinitialised or not. The PU does not dispatch threads on busy contexts.

## Timing
- Read latency 1: address at edge T, data valid after edge T+1.
- Write visible to non-bypassed reads issued the cycle after the write.
- Reinit: grant in cycle T. ctx_busy[id] is high for cycles T+1..T+DEPTH. The reinit write of register i occurs at the edge ending cycle T+1+i. init_done is high in cycle T+DEPTH. IDLE from cycle T+DEPTH+1, where a new grant is possible, giving back-to-back reinit every DEPTH+1 cycles.
- Reset asserted mid-INIT: FSM aborts immediately and all contexts are fully preloaded. No init_done is produced.
- init_gnt is the only combinational output; all others are registered.

## Test plan
- Reset then read ctx 3 addresses 8, 31 and 5 over NRD ports -> dout = CONNECTION_CONTEXT_BASE, RAS_BASE, 0 one cycle after each address.
- Write 0xDEADBEEF to ctx1 r7 while port0 reads ctx1 r7 in the same cycle -> BYPASS=1: 0xDEADBEEF next cycle. BYPASS=0: 0, then 0xDEADBEEF on the following read. Reading ctx2 r7 returns 0.
- Write 0x1234 to r0 of ctx0 -> subsequent read returns 0.
- Write 0xAAAA to ctx2 r9, then init_req ctx2 -> init_gnt=1, ctx_busy=4'b0100 for 32 cycles, init_done at the 32nd, after which r9 reads SWITCH_INFO_BASE.
- During ctx2 INIT: write ctx2 r20=0x55 (dropped, reads 0) and ctx0 r20=0x66 (reads 0x66). A second init_req during INIT -> init_gnt=0 until IDLE.
- Assert rst_n low at INIT pointer 10, after writing 0x77 to ctx0 r3 -> ctx_busy=0, no init_done, ctx0 r3 reads 0 and all contexts read preload values.
